median_window_gen: RTL and testbench
====================================

Name: median_window_gen

Overview:
- Upstream neighbour of median_filter: converts a raster-order 8-bit pixel stream into one 3x3 neighbourhood per pixel, in the same raster order.
- Contains two line buffers of IMG_W entries each, a 3x3 window register array and border handling.
- Emits exactly IMG_W*IMG_H windows per frame, then returns to idle ready for the next frame.

Parameters:
- IMG_W, 1080, image width in pixels (>=2).
- IMG_H, 1080, image height in pixels (>=2).
- PIX_W, 8, bits per pixel.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_pixel holds a valid pixel.
- in_pixel  in  PIX_W  raster-order pixel: row 0 first, column 0 first.
- in_ready  out  1  block accepts a pixel this cycle. A pixel is accepted when in_valid && in_ready.
- win_valid  out  1  win_data holds one window; one-cycle pulse per window; no backpressure.
- win_data  out  9*PIX_W  packed window. Slot k = 3*dy+dx sits at [k*PIX_W +: PIX_W], with dy,dx in 0..2 meaning offset -1..+1. k=4 is the centre; k=0 is top-left.
- win_row  out  16  row index of the window centre.
- win_col  out  16  column index of the window centre.
- done  out  1  one-cycle pulse coincident with the last win_valid of a frame.

Behaviour:
- Reset values (async, immediate): win_valid=0, win_data=0, win_row=0, win_col=0, done=0, state=IDLE, all counters 0. in_ready=0 while rst is high.
- Line-buffer contents are not cleared; border masking makes them irrelevant.
- States:
  - IDLE: in_ready=1. First accept -> FILL.
  - FILL: in_ready=1. Accepted count n < IMG_W+1; no windows emitted. Accept that makes n = IMG_W+1 -> RUN.
  - RUN: in_ready=1. Each accept advances one slot. The accept with n = IMG_W*IMG_H -> FLUSH.
  - FLUSH: in_ready=0. The block self-advances one virtual slot per cycle for exactly IMG_W+1 cycles. After the last slot -> IDLE.
- Slot rule: slot index s counts accepted pixels plus flush slots, from 0. At slot s >= IMG_W+1, the window for centre index m = s-IMG_W-1 is registered.
  - win_valid is high in the cycle after that slot.
  - win_row = m / IMG_W, win_col = m % IMG_W, maintained as counters (no divider).
- Latency: the first window appears 1 clock after accept #IMG_W+2. The last window appears 1 clock after the final flush cycle.
- in_valid gaps stall the stream with no loss or duplication. In FLUSH, in_valid is ignored and no pixel is consumed.
- Border handling (default, zero padding): any neighbour outside the frame reads 0. This covers row -1, row IMG_H, column -1 and column IMG_W, including left-edge wrap from the previous row.
- Arithmetic: all counters are unsigned and wide enough for IMG_W*IMG_H+IMG_W+1. No saturation is needed.
- done is asserted with window m = IMG_W*IMG_H-1. The FLUSH -> IDLE transition happens on that same edge, so in_ready returns high in the cycle done is high. Back-to-back frames need no gap.
- Reset mid-frame: everything aborts immediately. The next frame starts clean from IDLE, with no stale windows emitted.

Optional Feature:
- Macro: MEDIAN_WINDOW_REPLICATE_EN.
- Defined: out-of-frame neighbours take the value of the nearest in-frame pixel (coordinates clamped to 0..IMG_W-1 and 0..IMG_H-1). Corners clamp on both axes.
- Undefined: zero padding as described in Behaviour.
- Timing, counts and handshake are identical in both builds.

Test Plan:
All scenarios use IMG_W=4, IMG_H=3; the frame is the ramp 1..12 unless stated.
1. Ramp, zero padding, in_valid held high -> first win_valid 1 clock after accept #6. Window (0,0) slots k0..k8 = 0,0,0,0,1,2,0,5,6. Window (1,1) = 1,2,3,5,6,7,9,10,11.
2. Same run -> exactly 12 win_valid pulses. in_ready is low for exactly 5 flush cycles. Window (2,3) = 7,8,0,11,12,0,0,0,0, coincident with done=1.
3. MEDIAN_WINDOW_REPLICATE_EN defined -> window (0,0) = 1,1,2,1,1,2,5,5,6. Window (2,3) = 7,8,8,11,12,12,11,12,12.
4. in_valid toggled every other cycle -> window contents and row/col sequence identical to scenario 1; no duplicate or missing win_valid.
5. rst pulsed after 7 accepts -> win_valid, done and in_ready go to 0 immediately. A new frame of all 7s then gives window (1,1) = nine 7s and window (0,0) = 0,0,0,0,7,7,0,7,7.
6. Two ramp frames back-to-back -> 24 win_valid pulses and 2 done pulses. The second frame's first pixel is accepted in the done cycle.

Source files
------------

// File: rtl/median_window_gen.sv
// median_window_gen: turns a raster pixel stream into one 3x3 neighbourhood per pixel.
// Zero padding at the frame border; define MEDIAN_WINDOW_REPLICATE_EN for edge replication.
module median_window_gen #(
  parameter int IMG_W = 1080,
  parameter int IMG_H = 1080,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               in_ready,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win_data,
  output logic [15:0]        win_row,
  output logic [15:0]        win_col,
  output logic               done
);

  localparam int SW = $clog2(IMG_W*IMG_H + IMG_W + 2);
  localparam int CW = $clog2(IMG_W);
  localparam logic [SW-1:0] FillEnd   = SW'(IMG_W);
  localparam logic [SW-1:0] EmitStart = SW'(IMG_W + 1);
  localparam logic [SW-1:0] RunEnd    = SW'(IMG_W*IMG_H - 1);
  localparam logic [SW-1:0] FlushEnd  = SW'(IMG_W*IMG_H + IMG_W);
  localparam logic [CW-1:0] LastCol   = CW'(IMG_W - 1);
  localparam logic [15:0]   LastColW  = 16'(IMG_W - 1);
  localparam logic [15:0]   LastRow   = 16'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      slot_q;
  logic [CW-1:0]      inCol_q;
  logic [15:0]        mRow_q, mCol_q;
  logic [PIX_W-1:0]   lbTop_q [IMG_W];
  logic [PIX_W-1:0]   lbMid_q [IMG_W];
  logic [PIX_W-1:0]   colL_q [3];
  logic [PIX_W-1:0]   colM_q [3];
  logic [PIX_W-1:0]   newCol [3];
  logic [PIX_W-1:0]   raw [3][3];
  logic [9*PIX_W-1:0] winData_d;
  logic               advance, emit, lastSlot;

  // Flush slots advance on their own; otherwise one slot per accepted pixel.
  assign advance  = (state_q == FLUSH) || (in_valid && in_ready);
  assign emit     = advance && (slot_q >= EmitStart);
  assign lastSlot = (state_q == FLUSH) && (slot_q == FlushEnd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (slot_q == FillEnd) state_d = RUN;
        RUN:     if (slot_q == RunEnd) state_d = FLUSH;
        FLUSH:   if (slot_q == FlushEnd) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = !rst && (state_q != FLUSH);
  end

  // Slot, input column and window-centre position counters; all rewind at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= '0;
      inCol_q <= '0;
      mRow_q  <= '0;
      mCol_q  <= '0;
    end else if (advance) begin
      if (lastSlot) begin
        slot_q  <= '0;
        inCol_q <= '0;
        mRow_q  <= '0;
        mCol_q  <= '0;
      end else begin
        slot_q  <= slot_q + 1'b1;
        inCol_q <= (inCol_q == LastCol) ? '0 : inCol_q + 1'b1;
        if (emit) begin
          if (mCol_q == LastColW) begin
            mCol_q <= '0;
            mRow_q <= mRow_q + 1'b1;
          end else begin
            mCol_q <= mCol_q + 1'b1;
          end
        end
      end
    end
  end

  // Line buffers and window columns hold data only; border masking covers stale contents.
  always_ff @(posedge clk) begin
    if (advance) begin
      lbTop_q[inCol_q] <= lbMid_q[inCol_q];
      lbMid_q[inCol_q] <= newCol[2];
      for (int i = 0; i < 3; i++) begin
        colL_q[i] <= colM_q[i];
        colM_q[i] <= newCol[i];
      end
    end
  end

  always_comb begin
    newCol[0] = lbTop_q[inCol_q];
    newCol[1] = lbMid_q[inCol_q];
    newCol[2] = (state_q == FLUSH) ? '0 : in_pixel;
  end

  always_comb begin
    for (int dy = 0; dy < 3; dy++) begin
      raw[dy][0] = colL_q[dy];
      raw[dy][1] = colM_q[dy];
      raw[dy][2] = newCol[dy];
    end
  end

  // Column dx=1 of the raw window is always the centre column, so edges clamp onto it.
  always_comb begin
    logic rowOut, colOut;
`ifdef MEDIAN_WINDOW_REPLICATE_EN
    int sdy, sdx;
    sdy = 1;
    sdx = 1;
`endif
    winData_d = '0;
    rowOut    = 1'b0;
    colOut    = 1'b0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        rowOut = ((dy == 0) && (mRow_q == '0)) || ((dy == 2) && (mRow_q == LastRow));
        colOut = ((dx == 0) && (mCol_q == '0)) || ((dx == 2) && (mCol_q == LastColW));
`ifdef MEDIAN_WINDOW_REPLICATE_EN
        sdy = rowOut ? 1 : dy;
        sdx = colOut ? 1 : dx;
        winData_d[(3*dy+dx)*PIX_W +: PIX_W] = raw[sdy][sdx];
`else
        winData_d[(3*dy+dx)*PIX_W +: PIX_W] = (rowOut || colOut) ? '0 : raw[dy][dx];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
      done      <= 1'b0;
    end else begin
      win_valid <= emit;
      done      <= emit && lastSlot;
      if (emit) begin
        win_data <= winData_d;
        win_row  <= mRow_q;
        win_col  <= mCol_q;
      end
    end
  end

endmodule

// File: tb/tb_median_window_gen.sv
// tb_median_window_gen: scoreboard plus vector-table bench for median_window_gen (4x3 frames).
// Build with MEDIAN_WINDOW_REPLICATE_EN defined to exercise edge replication.
module tb_median_window_gen;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [PW-1:0]  in_pixel;
  logic           in_ready;
  logic           win_valid;
  logic [9*PW-1:0] win_data;
  logic [15:0]    win_row;
  logic [15:0]    win_col;
  logic           done;

  median_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .win_valid(win_valid), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] data;
    int          row;
    int          col;
    logic        isDone;
  } win_t;

  typedef struct {
    int          scen;
    int          row;
    int          col;
    logic [71:0] data;
  } vec_t;

  win_t        expQ[$];
  win_t        e;
  vec_t        vecs[5];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          pix[24];
  int          img[H][W];
  logic [71:0] cap[H][W];
  int          winCount, doneCount, notReadyCount, lastNotReadyCyc, doneCyc;
  int          firstWinCyc, accCount, acc6Cyc, doneAccept;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [71:0] pk(int a0, int a1, int a2, int a3, int a4,
                                     int a5, int a6, int a7, int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [71:0] modelWin(int r, int c);
    logic [71:0] d;
    int rr, cc;
    d = '0;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
`ifdef MEDIAN_WINDOW_REPLICATE_EN
      if (rr < 0) rr = 0;
      if (rr > H - 1) rr = H - 1;
      if (cc < 0) cc = 0;
      if (cc > W - 1) cc = W - 1;
      d[k*8 +: 8] = 8'(img[rr][cc]);
`else
      if (rr >= 0 && rr < H && cc >= 0 && cc < W) d[k*8 +: 8] = 8'(img[rr][cc]);
`endif
    end
    return d;
  endfunction

  task automatic pushFrame(input int base);
    win_t w;
    for (int i = 0; i < W*H; i++) img[i / W][i % W] = pix[base + i];
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        w.data   = modelWin(r, c);
        w.row    = r;
        w.col    = c;
        w.isDone = (r == H - 1) && (c == W - 1);
        expQ.push_back(w);
      end
    end
  endtask

  task automatic clearStats();
    winCount = 0; doneCount = 0; notReadyCount = 0; lastNotReadyCyc = -1;
    doneCyc = -1; firstWinCyc = -1; accCount = 0; acc6Cyc = -1; doneAccept = 0;
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each window.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        accCount++;
        if (accCount == 6) acc6Cyc = cyc;
        if (done) doneAccept++;
      end
      if (!in_ready) begin
        notReadyCount++;
        lastNotReadyCyc = cyc;
      end
      if (done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (win_valid) begin
        winCount++;
        if (winCount == 1) firstWinCyc = cyc;
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_window: got window row %0d col %0d, required none", win_row, win_col);
        end else begin
          e = expQ.pop_front();
          checkOutput("win_data", win_data, e.data);
          checkOutput("win_pos", {win_row, win_col}, {16'(e.row), 16'(e.col)});
          checkOutput("done_flag", done, e.isDone);
          cap[e.row][e.col] = win_data;
        end
      end
    end
  end

  task automatic applyStimulus(input int nPix, input bit toggle);
    int  i = 0;
    int  budget = 0;
    bit  phase = 1'b1;
    bit  hs;
    @(posedge clk); #1;
    while (i < nPix && budget < 400) begin
      in_valid = toggle ? phase : 1'b1;
      phase    = !phase;
      in_pixel = 8'(pix[i]);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      budget++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    checkOutput("accept_count", 72'(i), 72'(nPix));
  endtask

  task automatic waitDone(input int target);
    int budget = 0;
    while (doneCount < target && budget < 100) begin
      @(negedge clk); #1;
      budget++;
    end
    checkOutput("done_reached", 72'(doneCount >= target), 72'(1));
    @(posedge clk); #1;
  endtask

  task automatic checkTable(input int scen);
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].scen == scen)
        checkOutput($sformatf("vec_s%0d_r%0d_c%0d", scen, vecs[v].row, vecs[v].col),
                    cap[vecs[v].row][vecs[v].col], vecs[v].data);
    end
  endtask

  initial begin
`ifdef MEDIAN_WINDOW_REPLICATE_EN
    vecs[0] = '{1, 0, 0, pk(1, 1, 2, 1, 1, 2, 5, 5, 6)};
    vecs[1] = '{1, 1, 1, pk(1, 2, 3, 5, 6, 7, 9, 10, 11)};
    vecs[2] = '{1, 2, 3, pk(7, 8, 8, 11, 12, 12, 11, 12, 12)};
    vecs[3] = '{5, 1, 1, pk(7, 7, 7, 7, 7, 7, 7, 7, 7)};
    vecs[4] = '{5, 0, 0, pk(7, 7, 7, 7, 7, 7, 7, 7, 7)};
`else
    vecs[0] = '{1, 0, 0, pk(0, 0, 0, 0, 1, 2, 0, 5, 6)};
    vecs[1] = '{1, 1, 1, pk(1, 2, 3, 5, 6, 7, 9, 10, 11)};
    vecs[2] = '{1, 2, 3, pk(7, 8, 0, 11, 12, 0, 0, 0, 0)};
    vecs[3] = '{5, 1, 1, pk(7, 7, 7, 7, 7, 7, 7, 7, 7)};
    vecs[4] = '{5, 0, 0, pk(0, 0, 0, 0, 7, 7, 0, 7, 7)};
`endif
    clearStats();
    rst = 1'b1; in_valid = 1'b0; in_pixel = '0;
    @(posedge clk); #1;
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_outputs", {win_valid, done, win_row, win_col}, 0);
    checkOutput("reset_win_data", win_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", in_ready, 1);

    $display("[TB] scenario 1/2: ramp, in_valid held high");
    for (int i = 0; i < 24; i++) pix[i] = i % 12 + 1;
    clearStats();
    pushFrame(0);
    applyStimulus(12, 1'b0);
    waitDone(1);
    checkOutput("first_window_latency", 72'(firstWinCyc - acc6Cyc), 72'(1));
    checkOutput("window_count", 72'(winCount), 72'(12));
    checkOutput("flush_cycles", 72'(notReadyCount), 72'(5));
    checkOutput("last_window_latency", 72'(doneCyc - lastNotReadyCyc), 72'(1));
    checkOutput("done_count", 72'(doneCount), 72'(1));
    checkOutput("queue_empty", 72'(expQ.size()), 72'(0));
    checkTable(1);

    $display("[TB] scenario 4: in_valid toggled");
    clearStats();
    pushFrame(0);
    applyStimulus(12, 1'b1);
    waitDone(1);
    checkOutput("toggle_window_count", 72'(winCount), 72'(12));
    checkOutput("toggle_queue_empty", 72'(expQ.size()), 72'(0));
    checkTable(1);

    $display("[TB] scenario 5: reset mid-frame");
    clearStats();
    pushFrame(0);
    applyStimulus(7, 1'b0);
    checkOutput("pre_reset_win_valid", win_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_outputs", {win_valid, done, in_ready}, 0);
    expQ.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) pix[i] = 7;
    clearStats();
    pushFrame(0);
    applyStimulus(12, 1'b0);
    waitDone(1);
    checkOutput("restart_window_count", 72'(winCount), 72'(12));
    checkTable(5);

    $display("[TB] scenario 6: two frames back-to-back");
    for (int i = 0; i < 24; i++) pix[i] = i % 12 + 1;
    clearStats();
    pushFrame(0);
    pushFrame(12);
    applyStimulus(24, 1'b0);
    waitDone(2);
    checkOutput("b2b_window_count", 72'(winCount), 72'(24));
    checkOutput("b2b_done_count", 72'(doneCount), 72'(2));
    checkOutput("b2b_accept_in_done", 72'(doneAccept), 72'(1));
    checkOutput("b2b_queue_empty", 72'(expQ.size()), 72'(0));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
